// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the arbiter state encoding and the UART bit timing at 50 MHz / 9600 baud.
package uart_pkg;
  localparam int BYTE_W      = 8;
  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD        = 9600;
  localparam int CLK_PER_BIT = CLK_HZ / BAUD;  // 5208

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = producers plus the uart_tx model.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int GW = idx_w(N_REQ);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic [BYTE_W-1:0]            tx_data;
  logic                         tx_start;
  logic                         tx_busy;
  logic [GW-1:0]                grant_id;
  logic                         grant_active;
  logic                         err_tmo;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, grant_active, err_tmo
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, grant_active, err_tmo
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational masked round-robin select: first set bit of valid & mask,
// searching upward from ptr+1 with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] cand;
  logic [W-1:0] j;

  assign cand = valid & mask;
  assign any  = |cand;

  // Walk farthest-to-nearest so the nearest candidate after ptr is the last write.
  always_comb begin
    idx = '0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (cand[j]) idx = j;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// Optional packet lock: define UART_ARB_PKT_LOCK_EN to keep a grant until req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int BUSY_TMO = 4
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = idx_w(N_REQ);
  localparam int CW = $clog2(BUSY_TMO + 1);

  arb_state_t       state;
  logic [GW-1:0]    ptr;
  logic [GW-1:0]    win;
  logic             win_any;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] mask;

`ifdef UART_ARB_PKT_LOCK_EN
  logic          lock;
  logic [GW-1:0] lock_id;

  // While locked only the owning requester is eligible.
  always_comb mask = lock ? (N_REQ'(1) << lock_id) : '1;
`else
  logic unused_last;

  assign mask        = '1;
  assign unused_last = ^bus.req_last;
`endif

  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .valid (bus.req_valid),
    .mask  (mask),
    .ptr   (ptr),
    .idx   (win),
    .any   (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= GW'(N_REQ - 1);
      cnt              <= '0;
      bus.tx_data      <= '0;
      bus.tx_start     <= 1'b0;
      bus.req_ready    <= '0;
      bus.grant_id     <= '0;
      bus.grant_active <= 1'b0;
      bus.err_tmo      <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock             <= 1'b0;
      lock_id          <= '0;
`endif
    end else begin
      bus.tx_start  <= 1'b0;
      bus.req_ready <= '0;
      bus.err_tmo   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any && !bus.tx_busy) begin
            bus.tx_data       <= bus.req_data[win];
            bus.tx_start      <= 1'b1;
            bus.req_ready[win] <= 1'b1;
            bus.grant_id      <= win;
            bus.grant_active  <= 1'b1;
            ptr               <= win;
            cnt               <= '0;
            state             <= WAIT_BUSY;
`ifdef UART_ARB_PKT_LOCK_EN
            lock              <= !bus.req_last[win];
            lock_id           <= win;
`endif
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TMO - 1)) begin
            // Byte was already acknowledged to the requester; it is dropped.
            bus.err_tmo      <= 1'b1;
            bus.grant_active <= 1'b0;
            state            <= IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
            lock             <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            bus.grant_active <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
